uart_tx_fifo: RTL and testbench

Synthesizable UART transmitter with a small byte FIFO. It serializes bytes onto a single line as 8-bit frames (start, 8 data bits LSB first, optional parity, stop). It is the sending end of the line format that the simulation printf monitor decodes. A core or debug bridge pushes bytes through a valid/ready port. Byte 0x04 is passed through unchanged; the monitor treats it as end-of-simulation.

---
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: start, 8 data bits LSB first, optional parity, stop.
// Frames are sent back to back whenever the FIFO holds data at the end of a stop period.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_valid,
  input  logic [7:0]                            wr_data,
  output logic                                  wr_ready,
  output logic                                  uart_tx,
  output logic                                  busy,
  output logic                                  tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

  localparam int unsigned BIT_RAW    = CLK_HZ / BAUD_RATE;
  localparam int unsigned BIT_CYCLES = (BIT_RAW < 1) ? 1 : BIT_RAW;
  localparam int unsigned STOP_LEN   = STOP_BITS * BIT_CYCLES;
  localparam int unsigned CW         = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned NW         = $clog2(FIFO_DEPTH + 1);
  localparam logic        ODD_PAR    = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [NW-1:0]   r_count;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_done;

  logic            w_push;
  logic            w_pop;
  logic            w_nonempty;
  logic [7:0]      w_head;

  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign wr_ready   = (r_count != NW'(FIFO_DEPTH));
  assign w_push     = wr_valid && wr_ready;
  // A pop loads the shifter: from idle, or at the last cycle of a stop period.
  assign w_pop      = w_nonempty &&
                      ((r_state == StIdle) || ((r_state == StStop) && (r_cnt == '0)));

  assign uart_tx    = r_tx;
  assign tx_done    = r_done;
  assign fifo_count = r_count;
  assign busy       = (r_state != StIdle) || w_nonempty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (^w_head) ^ ODD_PAR;
            r_state <= StStart;
            r_tx    <= 1'b0;
            r_cnt   <= CW'(BIT_CYCLES - 1);
          end
        end
        StStart: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_idx   <= '0;
            r_cnt   <= CW'(BIT_CYCLES - 1);
          end
        end
        StData: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_idx != 3'd7) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_cnt   <= CW'(BIT_CYCLES - 1);
          end else if (PARITY != 0) begin
            r_state <= StParity;
            r_tx    <= r_par;
            r_cnt   <= CW'(BIT_CYCLES - 1);
          end else begin
            r_state <= StStop;
            r_tx    <= 1'b1;
            r_cnt   <= CW'(STOP_LEN - 1);
            r_done  <= (STOP_LEN == 1);
          end
        end
        StParity: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= StStop;
            r_tx    <= 1'b1;
            r_cnt   <= CW'(STOP_LEN - 1);
            r_done  <= (STOP_LEN == 1);
          end
        end
        StStop: begin
          // tx_done is raised so that it is high during the final stop cycle.
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CW'(1));
          end else if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (^w_head) ^ ODD_PAR;
            r_state <= StStart;
            r_tx    <= 1'b0;
            r_cnt   <= CW'(BIT_CYCLES - 1);
          end else begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked cycle by cycle against a line-level model
// that expands each accepted byte into its expected per-cycle serial levels.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] d;
  int         sel;
  logic [3:0] wv;
  logic [3:0] tx, done, bsy, rdy;
  logic [2:0] cnt [4];

  int checks = 0;
  int errors = 0;

  int bc_t [4] = '{8, 8, 8, 1};
  int par_t[4] = '{0, 1, 2, 0};
  int stp_t[4] = '{1, 1, 2, 1};

  logic       ml[$];
  logic [7:0] mf[$];
  logic       last_acc;

  always #5 clk = ~clk;

  assign wv = valid ? 4'(1 << sel) : 4'b0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    uart_tx_fifo #(
      .CLK_HZ    ((k == 3) ? 50 : 800),
      .BAUD_RATE (100),
      .FIFO_DEPTH(4),
      .PARITY    ((k == 1) ? 1 : ((k == 2) ? 2 : 0)),
      .STOP_BITS ((k == 2) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wv[k]),
      .wr_data   (d),
      .wr_ready  (rdy[k]),
      .uart_tx   (tx[k]),
      .busy      (bsy[k]),
      .tx_done   (done[k]),
      .fifo_count(cnt[k])
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (cfg %0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  function automatic void add_frame(input logic [7:0] b);
    int bc = bc_t[sel];
    for (int i = 0; i < bc; i++) ml.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < bc; i++) ml.push_back(b[j]);
    if (par_t[sel] != 0)
      for (int i = 0; i < bc; i++) ml.push_back((^b) ^ (par_t[sel] == 2));
    for (int i = 0; i < stp_t[sel] * bc; i++) ml.push_back(1'b1);
  endfunction

  // One clock edge of the reference: retire a line cycle, start the next frame, accept a byte.
  function automatic void model_edge(input logic v, input logic [7:0] dd);
    int pre = mf.size();
    last_acc = v && (pre != 4);
    if (ml.size() > 0) void'(ml.pop_front());
    if (ml.size() == 0 && pre > 0) add_frame(mf.pop_front());
    if (last_acc) mf.push_back(dd);
  endfunction

  task automatic check_outputs();
    int n = ml.size();
    chk("uart_tx", 8'(tx[sel]), (n > 0) ? 8'(ml[0]) : 8'd1);
    chk("tx_done", 8'(done[sel]), 8'(n == 1));
    chk("busy", 8'(bsy[sel]), 8'((n > 0) || (mf.size() > 0)));
    chk("wr_ready", 8'(rdy[sel]), 8'(mf.size() != 4));
    chk("fifo_count", 8'(cnt[sel]), 8'(mf.size()));
  endtask

  task automatic cycle(input logic v, input logic [7:0] dd);
    valid = v;
    d     = dd;
    @(posedge clk);
    model_edge(v, dd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  initial begin
    int j;
    rst   = 1'b1;
    valid = 1'b0;
    d     = 8'h00;
    sel   = 0;
    #12;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      check_outputs();
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      idle(2);
    end

    // Single 8N1 frame of 0x41, then idle until well past its tx_done.
    sel = 0;
    cycle(1'b1, 8'h41);
    idle(85);

    // Hold wr_valid with 0x10..0x15 so the FIFO fills and frames run back to back.
    j = 0;
    for (int c = 0; c < 700; c++) begin
      cycle(j < 6, 8'(8'h10 + j));
      if (last_acc) j++;
    end
    chk("all_bytes_accepted", 8'(j), 8'd6);

    // Parity even, then odd with two stop bits.
    sel = 1;
    cycle(1'b1, 8'h07);
    idle(100);
    sel = 2;
    cycle(1'b1, 8'h07);
    idle(110);

    // Reset during data bit 3 of 0x5A with two bytes queued.
    sel = 0;
    cycle(1'b1, 8'h5A);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    idle(33);
    chk("queued_before_reset", 8'(cnt[0]), 8'd2);
    #2 rst = 1'b1;
    #1;
    ml.delete();
    mf.delete();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(100);

    // One-cycle bits with the 0x04 sentinel byte.
    sel = 3;
    cycle(1'b1, 8'h04);
    idle(15);

    // Randomised traffic on the fast configuration, then on the parity configuration.
    for (int c = 0; c < 400; c++) cycle($urandom_range(0, 3) == 0, 8'($urandom));
    idle(60);
    sel = 1;
    for (int c = 0; c < 1500; c++) cycle($urandom_range(0, 39) == 0, 8'($urandom));
    idle(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
